alu64: RTL and testbench

ALU64 -- requirements
Module: alu64

---
 rtl/alu64.sv | 77 +++++++
 tb/tb_alu64.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/alu64.sv
// 64-bit registered ALU: ripple-carry slice chain for add/sub/logic, logical right shifter,
// flags and result captured together one cycle after the operands are presented.
module alu64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] A,
    input  logic [63:0] B,
    input  logic [2:0]  cntrl,
    input  logic [5:0]  shamt,
    output logic [63:0] result,
    output logic        negative,
    output logic        zero,
    output logic        overflow,
    output logic        carry_out
);

    logic [64:0] w_carry;
    logic [63:0] w_slice;
    logic [63:0] w_shift;
    logic [63:0] w_result;
    logic        w_arith;
    logic        w_ovf;
    logic        w_cout;

    logic [63:0] r_result;
    logic        r_negative;
    logic        r_zero;
    logic        r_overflow;
    logic        r_carry_out;

    // cntrl[0] doubles as B-invert and carry-in, so 011 computes A + ~B + 1.
    assign w_carry[0] = cntrl[0];

    for (genvar i = 0; i < 64; i++) begin : g_slice
        logic w_bi;
        logic w_sum;
        assign w_bi           = B[i] ^ cntrl[0];
        assign w_sum          = A[i] ^ w_bi ^ w_carry[i];
        assign w_carry[i + 1] = (A[i] & w_bi) | (w_carry[i] & (A[i] ^ w_bi));
        assign w_slice[i]     = (cntrl[2:1] == 2'b00) ? B[i] :
                                (cntrl[2:1] == 2'b01) ? w_sum :
                                (cntrl == 3'b100)     ? (A[i] & B[i]) :
                                (cntrl == 3'b101)     ? (A[i] | B[i]) :
                                                        (A[i] ^ B[i]);
    end

    assign w_shift  = A >> shamt;
    assign w_result = (cntrl == 3'b111) ? w_shift : w_slice;

    // Carry and overflow are only meaningful for add/subtract; forced low otherwise.
    assign w_arith = (cntrl[2:1] == 2'b01);
    assign w_cout  = w_arith & w_carry[64];
    assign w_ovf   = w_arith & (w_carry[63] ^ w_carry[64]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result    <= 64'd0;
            r_negative  <= 1'b0;
            r_zero      <= 1'b0;
            r_overflow  <= 1'b0;
            r_carry_out <= 1'b0;
        end else begin
            r_result    <= w_result;
            r_negative  <= w_result[63];
            r_zero      <= (w_result == 64'd0);
            r_overflow  <= w_ovf;
            r_carry_out <= w_cout;
        end
    end

    assign result    = r_result;
    assign negative  = r_negative;
    assign zero      = r_zero;
    assign overflow  = r_overflow;
    assign carry_out = r_carry_out;

endmodule

// File: tb/tb_alu64.sv
// Testbench for alu64: directed spec vectors, reset behaviour and randomized operations
// checked against an arithmetic reference model.
module tb_alu64;

    logic        clk;
    logic        rst_n;
    logic [63:0] A;
    logic [63:0] B;
    logic [2:0]  cntrl;
    logic [5:0]  shamt;
    logic [63:0] result;
    logic        negative;
    logic        zero;
    logic        overflow;
    logic        carry_out;

    int checks;
    int failures;

    typedef struct packed {
        logic [63:0] r;
        logic        n;
        logic        z;
        logic        v;
        logic        co;
    } exp_t;

    alu64 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .cntrl     (cntrl),
        .shamt     (shamt),
        .result    (result),
        .negative  (negative),
        .zero      (zero),
        .overflow  (overflow),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t ref_alu(input logic [63:0] a, input logic [63:0] b,
                                     input logic [2:0] c, input logic [5:0] s);
        exp_t        e;
        logic [64:0] wide;
        e = '0;
        case (c)
            3'd0, 3'd1: e.r = b;
            3'd2: begin
                wide = {1'b0, a} + {1'b0, b};
                e.r  = wide[63:0];
                e.co = wide[64];
                e.v  = (a[63] == b[63]) && (e.r[63] != a[63]);
            end
            3'd3: begin
                e.r  = a - b;
                e.co = (a >= b);
                e.v  = (a[63] != b[63]) && (e.r[63] != a[63]);
            end
            3'd4: e.r = a & b;
            3'd5: e.r = a | b;
            3'd6: e.r = a ^ b;
            default: e.r = a >> s;
        endcase
        e.n = e.r[63];
        e.z = (e.r == 64'd0);
        return e;
    endfunction

    task automatic chk64(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk64({tag, ".result"},    result,          e.r);
        chk64({tag, ".negative"},  {63'd0, negative},  {63'd0, e.n});
        chk64({tag, ".zero"},      {63'd0, zero},      {63'd0, e.z});
        chk64({tag, ".overflow"},  {63'd0, overflow},  {63'd0, e.v});
        chk64({tag, ".carry_out"}, {63'd0, carry_out}, {63'd0, e.co});
    endtask

    task automatic run(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic [2:0] c, input logic [5:0] s);
        A = a; B = b; cntrl = c; shamt = s;
        @(posedge clk);
        #1;
        chk_all(tag, ref_alu(a, b, c, s));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n = 1'b0;
        A = 64'hDEAD_BEEF_0000_0001; B = 64'h1; cntrl = 3'b010; shamt = 6'd0;

        // Held in reset across clock edges: everything stays cleared, zero included.
        #22;
        chk_all("reset", '0);
        rst_n = 1'b1;

        // First edge after release registers the operands present at that edge.
        run("first_after_reset", 64'd10, 64'd32, 3'b010, 6'd0);
        chk64("first_after_reset.val", result, 64'd42);

        run("zero_borrow", 64'd0, 64'd0, 3'b011, 6'd0);
        chk64("zero_borrow.zero", {63'd0, zero}, 64'd1);
        chk64("zero_borrow.co", {63'd0, carry_out}, 64'd1);

        run("signed_ovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 3'b010, 6'd0);
        chk64("signed_ovf.v", {63'd0, overflow}, 64'd1);
        chk64("signed_ovf.co", {63'd0, carry_out}, 64'd1);

        run("mixed_add", 64'd3784, -64'sd1259, 3'b010, 6'd0);
        chk64("mixed_add.val", result, 64'd2525);
        run("mixed_sub", 64'd3784, -64'sd1259, 3'b011, 6'd0);
        chk64("mixed_sub.val", result, 64'd5043);
        chk64("mixed_sub.co", {63'd0, carry_out}, 64'd0);

        run("neg_diff", 64'd2, 64'd4, 3'b011, 6'd0);
        chk64("neg_diff.val", result, 64'hFFFF_FFFF_FFFF_FFFE);

        run("and", 64'd250, 64'd150, 3'b100, 6'd0);
        chk64("and.val", result, 64'd146);
        run("or", 64'd250, 64'd150, 3'b101, 6'd0);
        chk64("or.val", result, 64'd254);
        run("xor", 64'd250, 64'd150, 3'b110, 6'd0);
        chk64("xor.val", result, 64'd108);
        run("pass0", 64'd250, 64'd150, 3'b000, 6'd0);
        chk64("pass0.val", result, 64'd150);
        run("pass1", 64'hFFFF_0000_FFFF_0000, 64'h8000_0000_0000_0000, 3'b001, 6'd5);

        run("shr63", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'b111, 6'd63);
        chk64("shr63.val", result, 64'd1);
        run("shr0", 64'h9234_5678_9ABC_DEF0, 64'd7, 3'b111, 6'd0);
        chk64("shr0.val", result, 64'h9234_5678_9ABC_DEF0);
        run("shr_zero_flag", 64'h0000_0000_0000_00FF, 64'd1, 3'b111, 6'd8);

        // Reset asserted between edges clears outputs immediately and drops the pending op.
        run("pre_reset", 64'd5, 64'd7, 3'b010, 6'd0);
        A = 64'hFFFF_FFFF_FFFF_FFFF; B = 64'd1; cntrl = 3'b010;
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("mid_reset", '0);
        @(posedge clk);
        #1;
        chk_all("mid_reset_edge", '0);
        #2;
        rst_n = 1'b1;
        run("post_reset", 64'd100, 64'd1, 3'b011, 6'd0);

        for (int i = 0; i < 300; i++) begin
            logic [63:0] ra;
            logic [63:0] rb;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if ((i % 7) == 0) rb = ra;
            if ((i % 11) == 0) rb = ~ra;
            run("rand", ra, rb, 3'($urandom_range(0, 7)), 6'($urandom_range(0, 63)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
